// File: rtl/efpga_cfg_pkg.sv
// Shared constants and types for the eFPGA configuration front-end.
// Covers the sync words, frame indices and decoder states.
package efpga_cfg_pkg;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0FAB0;

  localparam int FRAME_W    = 28;
  localparam int NUM_FRAMES = 7;

  localparam int FR_OUTV = 0;
  localparam int FR_OE   = 1;
  localparam int FR_LOOP = 2;
  localparam int FR_A_LO = 3;
  localparam int FR_A_HI = 4;
  localparam int FR_B_LO = 5;
  localparam int FR_B_HI = 6;

  typedef enum logic [1:0] {
    DEC_UNSYNCED  = 2'd0,
    DEC_SYNC_ADDR = 2'd1,
    DEC_SYNC_DATA = 2'd2
  } dec_state_t;

endpackage

// File: rtl/efpga_uart_rx.sv
// 8N1 UART receiver: input synchronizer, bit-timing FSM and one-cycle byte strobe.
// busy covers the span from the confirmed start bit through the stop-bit sample.
module efpga_uart_rx #(
  parameter int UART_DIV = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Rx,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       busy
);

  localparam int CNT_W = $clog2(UART_DIV + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(UART_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(UART_DIV - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic             rx_p0, rx_p1, rx_p2;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             sample_data;

  // Stage p0/p1: synchronizer; p2 is the previous synced value for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_p0    <= 1'b1;
      rx_p1    <= 1'b1;
      rx_p2    <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      byte_vld <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_p0    <= Rx;
      rx_p1    <= rx_p0;
      rx_p2    <= rx_p1;
      byte_vld <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_p2 && !rx_p1) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_p1) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == FULL_LAST) begin
            cnt      <= '0;
            busy     <= 1'b0;
            byte_vld <= rx_p1;
            state    <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign sample_data = (state == RX_DATA) && (cnt == FULL_LAST);

  always_ff @(posedge CLK) begin
    if (sample_data) shreg <= {rx_p1, shreg[7:1]};
  end

  assign byte_data = shreg;

endmodule

// File: rtl/efpga_top.sv
// eFPGA configuration front-end: UART / self-write / serial word sources,
// sync-word decoder, seven configuration frames and the top-edge pad shell.
module efpga_top
  import efpga_cfg_pkg::*;
#(
  parameter int UART_DIV     = 8,
  parameter int IDLE_TIMEOUT = 2048
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [27:0] O_top,
  output logic [27:0] I_top,
  output logic [27:0] T_top,
  output logic [55:0] A_config_C,
  output logic [55:0] B_config_C,
  input  logic        SelfWriteStrobe,
  input  logic [31:0] SelfWriteData,
  input  logic        Rx,
  output logic        ComActive,
  output logic        ReceiveLED,
  input  logic        s_clk,
  input  logic        s_data
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  logic              byte_vld;
  logic [7:0]        byte_data;
  logic [1:0]        byte_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [23:0]       uart_acc;
  logic              uart_word_vld;
  logic              uart_pend_vld;
  logic [31:0]       uart_pend;

  logic              sclk_p0, sclk_p1, sclk_p2;
  logic              sdat_p0, sdat_p1;
  logic              ser_rise;
  logic [4:0]        ser_bit_cnt;
  logic [31:0]       ser_shreg;
  logic              ser_word_vld;
  logic              ser_pend_vld;
  logic [31:0]       ser_pend;

  logic              dec_vld;
  logic [31:0]       dec_word;
  logic              uart_grant;
  logic              ser_grant;
  dec_state_t        dec_state;
  logic [2:0]        addr_q;
  logic [FRAME_W-1:0] frame_q [NUM_FRAMES];
  logic [27:0]       O_q;

  efpga_uart_rx #(
    .UART_DIV (UART_DIV)
  ) u_uart_rx (
    .CLK       (CLK),
    .RST       (RST),
    .Rx        (Rx),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .busy      (ReceiveLED)
  );

  // UART word assembly: first byte lands in [31:24]; silence resets the byte position.
  assign uart_word_vld = byte_vld && (byte_cnt == 2'd3);

  always_ff @(posedge CLK) begin
    if (RST) begin
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else if (byte_vld) begin
      byte_cnt <= byte_cnt + 2'd1;
      idle_cnt <= '0;
    end else if (idle_cnt == IDLE_LAST) begin
      byte_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (byte_vld)      uart_acc  <= {uart_acc[15:0], byte_data};
    if (uart_word_vld) uart_pend <= {uart_acc, byte_data};
  end

  // Stage p0/p1: serial port synchronizers; sclk_p2 holds the previous synced clock.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_p0     <= 1'b0;
      sclk_p1     <= 1'b0;
      sclk_p2     <= 1'b0;
      ser_bit_cnt <= '0;
    end else begin
      sclk_p0 <= s_clk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      if (ser_rise) ser_bit_cnt <= ser_bit_cnt + 5'd1;
    end
  end

  assign ser_rise     = sclk_p1 && !sclk_p2;
  assign ser_word_vld = ser_rise && (ser_bit_cnt == 5'd31);

  always_ff @(posedge CLK) begin
    sdat_p0 <= s_data;
    sdat_p1 <= sdat_p0;
    if (ser_rise)     ser_shreg <= {ser_shreg[30:0], sdat_p1};
    if (ser_word_vld) ser_pend  <= {ser_shreg[30:0], sdat_p1};
  end

  // A newly completed word replaces whatever that source still has pending.
  always_ff @(posedge CLK) begin
    if (RST) begin
      uart_pend_vld <= 1'b0;
      ser_pend_vld  <= 1'b0;
    end else begin
      if (uart_word_vld)   uart_pend_vld <= 1'b1;
      else if (uart_grant) uart_pend_vld <= 1'b0;
      if (ser_word_vld)    ser_pend_vld  <= 1'b1;
      else if (ser_grant)  ser_pend_vld  <= 1'b0;
    end
  end

  always_comb begin
    dec_vld    = 1'b0;
    dec_word   = '0;
    uart_grant = 1'b0;
    ser_grant  = 1'b0;
    if (SelfWriteStrobe) begin
      dec_vld  = 1'b1;
      dec_word = SelfWriteData;
    end else if (uart_pend_vld) begin
      dec_vld    = 1'b1;
      dec_word   = uart_pend;
      uart_grant = 1'b1;
    end else if (ser_pend_vld) begin
      dec_vld   = 1'b1;
      dec_word  = ser_pend;
      ser_grant = 1'b1;
    end
  end

  // Decoder: address/data word pairs once synced; address 7 matches no frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dec_state <= DEC_UNSYNCED;
      addr_q    <= '0;
      for (int i = 0; i < NUM_FRAMES; i++) frame_q[i] <= '0;
    end else if (dec_vld) begin
      case (dec_state)
        DEC_UNSYNCED: begin
          if (dec_word == SYNC_WORD) dec_state <= DEC_SYNC_ADDR;
        end
        DEC_SYNC_ADDR: begin
          if (dec_word == DESYNC_WORD) begin
            dec_state <= DEC_UNSYNCED;
          end else if (dec_word != SYNC_WORD) begin
            addr_q    <= dec_word[2:0];
            dec_state <= DEC_SYNC_DATA;
          end
        end
        DEC_SYNC_DATA: begin
          for (int i = 0; i < NUM_FRAMES; i++) begin
            if (addr_q == 3'(i)) frame_q[i] <= dec_word[FRAME_W-1:0];
          end
          dec_state <= DEC_SYNC_ADDR;
        end
        default: dec_state <= DEC_UNSYNCED;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    O_q <= O_top;
  end

  assign I_top      = (frame_q[FR_LOOP] & O_q) | (~frame_q[FR_LOOP] & frame_q[FR_OUTV]);
  assign T_top      = ~frame_q[FR_OE];
  assign A_config_C = {frame_q[FR_A_HI], frame_q[FR_A_LO]};
  assign B_config_C = {frame_q[FR_B_HI], frame_q[FR_B_LO]};
  assign ComActive  = (dec_state != DEC_UNSYNCED);

endmodule

// File: tb/tb_efpga_top.sv
// Directed bench for efpga_top: self-write vector table plus UART, serial,
// framing-error, simultaneous-source, idle-timeout and mid-frame reset sequences.
module tb_efpga_top;

  localparam int UDIV = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [27:0] O_top = '0;
  logic [27:0] I_top, T_top;
  logic [55:0] A_config_C, B_config_C;
  logic        SelfWriteStrobe = 1'b0;
  logic [31:0] SelfWriteData = '0;
  logic        Rx = 1'b1;
  logic        ComActive, ReceiveLED;
  logic        s_clk = 1'b0;
  logic        s_data = 1'b0;

  int checks = 0;
  int errors = 0;
  logic led_mid = 1'b0;

  efpga_top #(.UART_DIV(UDIV), .IDLE_TIMEOUT(2048)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .O_top           (O_top),
    .I_top           (I_top),
    .T_top           (T_top),
    .A_config_C      (A_config_C),
    .B_config_C      (B_config_C),
    .SelfWriteStrobe (SelfWriteStrobe),
    .SelfWriteData   (SelfWriteData),
    .Rx              (Rx),
    .ComActive       (ComActive),
    .ReceiveLED      (ReceiveLED),
    .s_clk           (s_clk),
    .s_data          (s_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] word;
    logic        com;
    logic [27:0] i_exp;
    logic [27:0] t_exp;
    logic [55:0] a_exp;
    logic [55:0] b_exp;
  } vec_t;

  vec_t vecs [15];

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    Rx = 1'b0;
    tick(UDIV);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      tick(UDIV);
      if (i == 3) led_mid = ReceiveLED;
    end
    Rx = stop;
    tick(UDIV);
    Rx = 1'b1;
    tick(2 * UDIV);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic self_write(input logic [31:0] w);
    SelfWriteData   = w;
    SelfWriteStrobe = 1'b1;
    tick(1);
    SelfWriteStrobe = 1'b0;
    tick(1);
  endtask

  task automatic ser_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) begin
      s_data = w[i];
      s_clk  = 1'b0;
      tick(3);
      s_clk  = 1'b1;
      tick(3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'hFAB0FAB1, 1'b1, 28'h0, 28'hFFFFFF0, 56'h0, 56'h0};
    vecs[1]  = '{32'h00000002, 1'b1, 28'h0, 28'hFFFFFF0, 56'h0, 56'h0};
    vecs[2]  = '{32'h00000001, 1'b1, 28'h0, 28'hFFFFFF0, 56'h0, 56'h0};
    vecs[3]  = '{32'h00000000, 1'b1, 28'h0, 28'hFFFFFF0, 56'h0, 56'h0};
    vecs[4]  = '{32'h00000005, 1'b1, 28'h4, 28'hFFFFFF0, 56'h0, 56'h0};
    vecs[5]  = '{32'h00000003, 1'b1, 28'h4, 28'hFFFFFF0, 56'h0, 56'h0};
    vecs[6]  = '{32'hF1234567, 1'b1, 28'h4, 28'hFFFFFF0, 56'h00000001234567, 56'h0};
    vecs[7]  = '{32'h00000007, 1'b1, 28'h4, 28'hFFFFFF0, 56'h00000001234567, 56'h0};
    vecs[8]  = '{32'hFFFFFFFF, 1'b1, 28'h4, 28'hFFFFFF0, 56'h00000001234567, 56'h0};
    vecs[9]  = '{32'h00000006, 1'b1, 28'h4, 28'hFFFFFF0, 56'h00000001234567, 56'h0};
    vecs[10] = '{32'h00ABCDEF, 1'b1, 28'h4, 28'hFFFFFF0, 56'h00000001234567, 56'h0ABCDEF0000000};
    vecs[11] = '{32'hFAB0FAB0, 1'b0, 28'h4, 28'hFFFFFF0, 56'h00000001234567, 56'h0ABCDEF0000000};
    vecs[12] = '{32'h00000000, 1'b0, 28'h4, 28'hFFFFFF0, 56'h00000001234567, 56'h0ABCDEF0000000};
    vecs[13] = '{32'h00000001, 1'b0, 28'h4, 28'hFFFFFF0, 56'h00000001234567, 56'h0ABCDEF0000000};
    vecs[14] = '{32'hFAB0FAB1, 1'b1, 28'h4, 28'hFFFFFF0, 56'h00000001234567, 56'h0ABCDEF0000000};

    // Reset values
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    check("rst_T", 64'(T_top), 64'hFFFFFFF);
    check("rst_I", 64'(I_top), 64'h0);
    check("rst_A", 64'(A_config_C), 64'h0);
    check("rst_B", 64'(B_config_C), 64'h0);
    check("rst_com", 64'(ComActive), 64'h0);
    check("rst_led", 64'(ReceiveLED), 64'h0);

    // UART configuration: sync, then OE = 0xF
    send_word(32'hFAB0FAB1);
    check("uart_sync_com", 64'(ComActive), 64'h1);
    check("uart_led_mid", 64'(led_mid), 64'h1);
    check("uart_led_idle", 64'(ReceiveLED), 64'h0);
    send_word(32'h00000001);
    send_word(32'h0000000F);
    check("uart_oe_T", 64'(T_top), 64'hFFFFFF0);

    // Self-write vector table
    for (int v = 0; v < 15; v++) begin
      self_write(vecs[v].word);
      check($sformatf("vec%0d_com", v), 64'(ComActive), 64'(vecs[v].com));
      check($sformatf("vec%0d_I", v), 64'(I_top), 64'(vecs[v].i_exp));
      check($sformatf("vec%0d_T", v), 64'(T_top), 64'(vecs[v].t_exp));
      check($sformatf("vec%0d_A", v), 64'(A_config_C), 64'(vecs[v].a_exp));
      check($sformatf("vec%0d_B", v), 64'(B_config_C), 64'(vecs[v].b_exp));
    end

    // Loopback: O_top reaches I_top one cycle after it is driven
    O_top = 28'h1;
    check("loop_before", 64'(I_top), 64'h4);
    tick(1);
    check("loop_after", 64'(I_top), 64'h5);

    // Serial to bus A high frame
    ser_word(32'hFAB0FAB1);
    ser_word(32'h00000004);
    ser_word(32'h0ABCDEF1);
    tick(6);
    check("ser_A", 64'(A_config_C), 64'hABCDEF11234567);
    check("ser_com", 64'(ComActive), 64'h1);

    // Framing error byte must not shift the word alignment
    send_byte(8'hA5, 1'b0);
    send_word(32'hFAB0FAB0);
    check("frame_err_desync", 64'(ComActive), 64'h0);

    // Self-write in the same cycle the UART word completes
    self_write(32'hFAB0FAB1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h07, 1'b1);
    fork
      send_byte(8'h77, 1'b1);
      begin
        int n;
        n = 0;
        while (ReceiveLED !== 1'b1 && n < 500) begin @(negedge CLK); n++; end
        while (ReceiveLED !== 1'b0 && n < 1000) begin @(negedge CLK); n++; end
        check("simul_led_seen", 64'(n < 1000 && n > 0), 64'h1);
        SelfWriteData   = 32'h00000005;
        SelfWriteStrobe = 1'b1;
        @(negedge CLK);
        SelfWriteStrobe = 1'b0;
      end
    join
    tick(4);
    check("simul_B", 64'(B_config_C), 64'h0ABCDEF0000777);
    check("simul_I", 64'(I_top), 64'h5);
    check("simul_com", 64'(ComActive), 64'h1);

    // Idle timeout clears a partial word
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(2100);
    send_word(32'hFAB0FAB0);
    check("idle_timeout_desync", 64'(ComActive), 64'h0);

    // Reset in the middle of a UART frame
    self_write(32'hFAB0FAB1);
    Rx = 1'b0;
    tick(30);
    check("midrst_led_busy", 64'(ReceiveLED), 64'h1);
    RST = 1'b1;
    Rx  = 1'b1;
    tick(2);
    RST = 1'b0;
    check("midrst_led", 64'(ReceiveLED), 64'h0);
    check("midrst_com", 64'(ComActive), 64'h0);
    check("midrst_T", 64'(T_top), 64'hFFFFFFF);
    check("midrst_A", 64'(A_config_C), 64'h0);
    check("midrst_B", 64'(B_config_C), 64'h0);
    check("midrst_I", 64'(I_top), 64'h0);
    send_word(32'hFAB0FAB1);
    check("midrst_resync", 64'(ComActive), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/efpga_top.md
# efpga_top

Configuration front-end and I/O shell of the small eFPGA.
- Accepts a configuration bitstream from one of three sources: UART (`Rx`), a parallel self-write port, or a two-wire serial port (`s_clk`/`s_data`).
- Decodes the bitstream into seven 28-bit configuration frames.
- Drives the 28 top-edge pads and the two 56-bit configuration buses from those frames.

## Interface
Parameters:
- `UART_DIV`, 8: CLK cycles per UART bit.
- `IDLE_TIMEOUT`, 2048: CLK cycles of UART silence that clear the partial-word byte count.

Ports:
- `CLK` in 1: single system clock, rising edge.
- `RST` in 1: reset; synchronous, active-high.
- `O_top` in 28: pad input values from the fabric edge.
- `I_top` out 28: pad output values.
- `T_top` out 28: pad tristate; 1 means high-Z/input.
- `A_config_C` out 56: configuration bus A.
- `B_config_C` out 56: configuration bus B.
- `SelfWriteStrobe` in 1: one-cycle strobe; the word on `SelfWriteData` is valid.
- `SelfWriteData` in 32: self-write word.
- `Rx` in 1: UART receive line, idle high, 8N1, LSB first.
- `ComActive` out 1: high while the decoder is SYNCED.
- `ReceiveLED` out 1: high while the UART receiver is inside a frame.
- `s_clk` in 1: serial shift clock, asynchronous to CLK.
- `s_data` in 1: serial data, sampled on the `s_clk` rising edge.

## Operation
- **Input sync.** `Rx`, `s_clk` and `s_data` each pass through a 2-flop synchronizer.
- **UART receiver.**
  - IDLE waits for a falling edge of synced `Rx`, then waits `UART_DIV/2` cycles and re-checks the line.
  - If the line is high, the receiver returns to IDLE (glitch).
  - Otherwise it samples 8 data bits, one every `UART_DIV` cycles, LSB first, then samples the stop bit.
  - Stop bit = 1: emit a one-cycle byte strobe. Stop bit = 0: discard the byte (framing error).
  - `ReceiveLED` is high from the confirmed start bit through the stop-bit sample.
- **UART word assembly.** Four bytes form one word, first byte in [31:24].
  - A byte counter wraps at 4.
  - The counter clears after `IDLE_TIMEOUT` cycles without a byte strobe.
- **Serial port.**
  - On each synced `s_clk` rising edge, shift `s_data` into a 32-bit register, MSB first.
  - After 32 bits, emit a word and clear the bit count.
- **Arbitration.**
  - UART and serial each own a one-word pending register.
  - Priority on the same cycle: SelfWrite, then UART, then serial.
  - A pending word waits until it wins arbitration.
  - A new UART or serial word arriving while that source's pending register is full overwrites it.
- **Decoder FSM.**
  - UNSYNCED: all words are ignored except 0xFAB0FAB1, which moves to SYNC_ADDR.
  - SYNC_ADDR:
    - 0xFAB0FAB0 moves to UNSYNCED.
    - 0xFAB0FAB1 stays in SYNC_ADDR.
    - Any other word latches the frame address from bits [2:0] and moves to SYNC_DATA.
  - SYNC_DATA: the word is written as data, then the FSM returns to SYNC_ADDR.
    - Bits [27:0] go to the addressed frame.
    - Address 7 is discarded.
  - `ComActive` = (state != UNSYNCED).
- **Frames.**
  - 0 = OUTV
  - 1 = OE
  - 2 = LOOP
  - 3 = A_config_C[27:0]
  - 4 = A_config_C[55:28]
  - 5 = B_config_C[27:0]
  - 6 = B_config_C[55:28]
- **Pads.**
  - `O_top` is registered once into `O_q`.
  - `I_top[i]` = LOOP[i] ? `O_q`[i] : OUTV[i].
  - `T_top[i]` = ~OE[i].

## Timing
- **Reset.**
  - All frames = 0 and the FSM is UNSYNCED.
  - UART receiver is IDLE; byte, bit and timeout counters = 0; pending registers are empty.
  - Resulting outputs: `I_top`=0, `T_top`=all ones, `A_config_C`=0, `B_config_C`=0, `ComActive`=0, `ReceiveLED`=0.
  - `RST` mid-frame or mid-word aborts all partial state.
- **Latency.**
  - An accepted data word updates its frame on the next CLK edge; the change is visible on outputs in that same cycle.
  - `O_top` to `I_top` in loopback: 1 cycle.
- **UART byte strobe.** 2 (sync) + `UART_DIV/2` + 9·`UART_DIV` cycles after the `Rx` falling edge.
- **SelfWrite.** The strobe is consumed in the cycle it is asserted; there is no backpressure.
- **Serial.** `s_clk` high and low phases must each last ≥2 CLK cycles.

## Structure
- **Shared package `efpga_cfg_pkg`:**
  - constants SYNC_WORD=32'hFAB0FAB1 and DESYNC_WORD=32'hFAB0FAB0
  - frame index constants 0–6
  - decoder state enum
- **Sub-module `efpga_uart_rx`:** synchronizer, UART FSM, byte strobe, busy (drives `ReceiveLED`).
- Everything else lives in `efpga_top`.

## Test plan
- **Reset values:** assert `RST` for 2 cycles -> `T_top`=28'hFFFFFFF, `I_top`=0, `A_config_C`=`B_config_C`=0, `ComActive`=0.
- **UART configuration:** send bytes FA B0 FA B1, 00 00 00 01, 00 00 00 0F over UART (`UART_DIV`=8) -> `ComActive`=1 after the 4th byte; then `T_top`=28'hFFFFFF0.
- **Self-write loopback:** strobe 0xFAB0FAB1, 2, 0x0000_0001 -> LOOP[0]=1; drive `O_top[0]`=1 -> `I_top[0]`=1 one cycle later.
- **Serial to bus A:** shift 0xFAB0FAB1, 4, 0x0ABCDEF1 serially -> `A_config_C[55:28]`=28'hABCDEF1.
- **Desync and framing error:**
  - Send 0xFAB0FAB0 -> `ComActive`=0; a following write (address 0, data 1) leaves OUTV unchanged.
  - A UART byte with stop bit 0 is dropped and the byte count does not advance.
- **Simultaneous sources:** SelfWrite strobe in the same cycle a UART word completes -> the SelfWrite word is processed first and the UART word on the next cycle; both writes land.
